// File: rtl/fp_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_alu_arbiter
// Brief    : Round-robin arbiter sharing one pipelined FP vector ALU between
//            several clients. An in-order tag FIFO routes each result strobe
//            back to its issuer; issue stalls while a mode change would mix
//            dot-product and vector-multiply operations in the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module fp_alu_arbiter #(
    parameter int WIDTH           = 32,
    parameter int NUM_INPUTS      = 169,
    parameter int NUM_REQUESTERS  = 2,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_REQUESTERS-1:0]                  req_valid,
    output logic [NUM_REQUESTERS-1:0]                  req_ready,
    input  logic [NUM_REQUESTERS-1:0]                  req_mode,
    input  logic [NUM_REQUESTERS*NUM_INPUTS*WIDTH-1:0] req_a,
    input  logic [NUM_REQUESTERS*NUM_INPUTS*WIDTH-1:0] req_b,
    input  logic [NUM_REQUESTERS*WIDTH-1:0]            req_c,
    input  logic [NUM_REQUESTERS*NUM_INPUTS-1:0]       req_enable,
    output logic [NUM_REQUESTERS-1:0]                  resp_valid,
    output logic [WIDTH-1:0]                           resp_dot_out,
    output logic [NUM_INPUTS*WIDTH-1:0]                resp_vec_out,
    output logic                                       alu_in_valid,
    input  logic                                       alu_in_ready,
    output logic                                       alu_mode,
    output logic [NUM_INPUTS*WIDTH-1:0]                alu_a,
    output logic [NUM_INPUTS*WIDTH-1:0]                alu_b,
    output logic [WIDTH-1:0]                           alu_c,
    output logic [NUM_INPUTS-1:0]                      alu_enable,
    input  logic                                       alu_out_valid,
    input  logic [WIDTH-1:0]                           alu_dot_out,
    input  logic [NUM_INPUTS*WIDTH-1:0]                alu_vec_out,
    output logic                                       protocol_error
);

    localparam int c_IDX_W = $clog2(NUM_REQUESTERS);
    localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_VEC_W = NUM_INPUTS * WIDTH;
    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQUESTERS - 1);

    logic [c_IDX_W-1:0] r_rr_ptr;
    logic               r_cur_mode;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic               r_protocol_error;

    int                 w_scan;
    logic               w_found;
    logic [c_IDX_W-1:0] w_grant;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [c_IDX_W-1:0] w_head;

    // Round-robin scan: first valid requester starting at r_rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_scan  = 0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= NUM_REQUESTERS) begin
                w_scan = w_scan - NUM_REQUESTERS;
            end
            if (!w_found && req_valid[w_scan]) begin
                w_found = 1'b1;
                w_grant = w_scan[c_IDX_W-1:0];
            end
        end
    end

    // Operand mux from the candidate slice; zeros when nobody is requesting.
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_c      = '0;
        alu_enable = '0;
        if (w_found) begin
            alu_a      = req_a[int'(w_grant)*c_VEC_W +: c_VEC_W];
            alu_b      = req_b[int'(w_grant)*c_VEC_W +: c_VEC_W];
            alu_c      = req_c[int'(w_grant)*WIDTH +: WIDTH];
            alu_enable = req_enable[int'(w_grant)*NUM_INPUTS +: NUM_INPUTS];
        end
    end

    // No bypass: a blocked candidate blocks everyone, which avoids starvation.
    // The full test uses the registered count, so a same-cycle pop cannot
    // unblock issue.
    assign w_issue = w_found && !rst && (r_count < c_MAX_CNT) &&
                     ((r_count == '0) || (req_mode[w_grant] == r_cur_mode));
    assign w_push  = w_issue && alu_in_ready;
    assign w_pop   = alu_out_valid && (r_count != '0) && !rst;
    assign w_head  = r_fifo[r_rd_ptr];

    assign alu_in_valid = w_issue;
    assign alu_mode     = (r_count == '0) ? req_mode[w_grant] : r_cur_mode;
    assign resp_dot_out = alu_dot_out;
    assign resp_vec_out = alu_vec_out;

    // One-hot accept for the winner and one-hot result strobe for the FIFO head.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (w_push) begin
            req_ready[w_grant] = 1'b1;
        end
        if (w_pop) begin
            resp_valid[w_head] = 1'b1;
        end
    end

    // Arbitration state, FIFO pointers/occupancy and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr         <= '0;
            r_cur_mode       <= 1'b0;
            r_count          <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_cur_mode <= req_mode[w_grant];
                r_rr_ptr   <= (w_grant == c_LAST_IDX) ? '0 : w_grant + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (alu_out_valid && (r_count == '0)) begin
                r_protocol_error <= 1'b1;
            end
        end
    end

    // Tag storage: issuing requester index, read back in issue order.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_grant;
        end
    end

    assign protocol_error = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_fp_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_alu_arbiter
// Brief    : Self-checking bench for fp_alu_arbiter: directed scenarios plus a
//            randomized run compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_alu_arbiter;

    localparam int W  = 16;
    localparam int NI = 4;
    localparam int NR = 2;
    localparam int MO = 4;
    localparam int VW = NI * W;
    localparam int AW = NR * VW;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid, req_ready, req_mode, resp_valid;
    logic [AW-1:0] req_a, req_b;
    logic [NR*W-1:0]  req_c;
    logic [NR*NI-1:0] req_enable;
    logic [W-1:0]  resp_dot_out, alu_c, alu_dot_out;
    logic [VW-1:0] resp_vec_out, alu_a, alu_b, alu_vec_out;
    logic [NI-1:0] alu_enable;
    logic          alu_in_valid, alu_in_ready, alu_mode, alu_out_valid, protocol_error;

    fp_alu_arbiter #(.WIDTH(W), .NUM_INPUTS(NI), .NUM_REQUESTERS(NR), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_enable(req_enable),
        .resp_valid(resp_valid), .resp_dot_out(resp_dot_out), .resp_vec_out(resp_vec_out),
        .alu_in_valid(alu_in_valid), .alu_in_ready(alu_in_ready), .alu_mode(alu_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_enable(alu_enable),
        .alu_out_valid(alu_out_valid), .alu_dot_out(alu_dot_out), .alu_vec_out(alu_vec_out),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Environment ALU: fixed-latency result pipe fed by accepted operations.
    bit       use_pipe = 1'b0;
    bit [7:0] pipe     = '0;
    int       lat      = 3;

    // Reference model state.
    int m_rr   = 0;
    bit m_mode = 1'b0;
    bit m_err  = 1'b0;
    int m_q[$];

    function automatic int m_cand();
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_rr + k) % NR]) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    function automatic bit m_issue();
        int c = m_cand();
        if (rst || c < 0 || m_q.size() >= MO) return 1'b0;
        return (m_q.size() == 0) || (req_mode[c] == m_mode);
    endfunction

    function automatic logic [NR-1:0] m_resp();
        logic [NR-1:0] r = '0;
        if (!rst && alu_out_valid && m_q.size() > 0) r[m_q[0]] = 1'b1;
        return r;
    endfunction

    task automatic m_commit();
        int c   = m_cand();
        bit iss = m_issue();
        if (rst) begin
            m_rr = 0; m_mode = 1'b0; m_err = 1'b0; m_q.delete();
        end else begin
            if (alu_out_valid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (iss && alu_in_ready) begin
                m_q.push_back(c);
                m_mode = req_mode[c];
                m_rr   = (c + 1) % NR;
            end
        end
    endtask

    function automatic logic [AW-1:0] rnd_bits();
        logic [AW-1:0] v;
        for (int i = 0; i < AW; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic tick();
        bit hs = alu_in_valid && alu_in_ready;
        m_commit();
        @(posedge clk);
        #1;
        pipe = {pipe[6:0], hs};
        if (use_pipe) alu_out_valid = pipe[lat-1];
        alu_dot_out = W'($urandom);
        alu_vec_out = rnd_bits()[VW-1:0];
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_mode = '0; alu_in_ready = 1'b1;
        alu_out_valid = 1'b0; use_pipe = 1'b0;
        tick(); tick();
        rst = 1'b0; pipe = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_mode = '0; alu_in_ready = 1'b1; alu_out_valid = 1'b1;
        req_a = rnd_bits(); req_b = rnd_bits(); req_c = '0; req_enable = '1;
        tick();
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        total++; if (alu_in_valid !== 1'b0) begin bad++; $display("FAIL rst_in_valid: got %b want 0", alu_in_valid); end
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL rst_resp: got %b want 00", resp_valid); end
        tick();
        #1;
        total++; if (protocol_error !== 1'b0) begin bad++; $display("FAIL rst_perr: got %b want 0", protocol_error); end
        rst = 1'b0; alu_out_valid = 1'b0; req_valid = '0;
        #1;
        total++; if (alu_in_valid !== 1'b0) begin bad++; $display("FAIL idle_in_valid: got %b want 0", alu_in_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        use_pipe = 1'b1; lat = 3; req_valid = 2'b11; req_mode = 2'b00;
        for (int k = 0; k < 12; k++) begin
            #1;
            total++;
            if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (k >= 3) begin
                total++;
                if (resp_valid !== (((k - 3) % 2 == 0) ? 2'b01 : 2'b10)) begin
                    bad++; $display("FAIL rr_resp[%0d]: got %b want %b", k, resp_valid, ((k - 3) % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            total++;
            if (resp_vec_out !== alu_vec_out || resp_dot_out !== alu_dot_out) begin
                bad++; $display("FAIL rr_passthru[%0d]: got %h/%h want %h/%h", k, resp_vec_out, resp_dot_out, alu_vec_out, alu_dot_out);
            end
            tick();
        end
        use_pipe = 1'b0;
    endtask

    task automatic test_solo();
        do_reset();
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL solo_first: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL solo_then0: got %b want 01", req_ready); end
        tick();
    endtask

    task automatic test_mode_switch();
        do_reset();
        req_valid = 2'b01; req_mode = 2'b01;
        #1;
        total++; if (alu_in_valid !== 1'b1 || alu_mode !== 1'b1) begin
            bad++; $display("FAIL ms_dot_issue: got v=%b m=%b want v=1 m=1", alu_in_valid, alu_mode); end
        tick();
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (alu_in_valid !== 1'b0 || req_ready !== 2'b00 || alu_mode !== 1'b1) begin
                bad++; $display("FAIL ms_stall[%0d]: got v=%b r=%b m=%b want v=0 r=00 m=1", k, alu_in_valid, req_ready, alu_mode); end
            tick();
        end
        alu_out_valid = 1'b1;
        #1;
        total++; if (resp_valid !== 2'b01 || alu_in_valid !== 1'b0) begin
            bad++; $display("FAIL ms_pop: got resp=%b v=%b want resp=01 v=0", resp_valid, alu_in_valid); end
        tick();
        alu_out_valid = 1'b0;
        #1;
        total++; if (alu_in_valid !== 1'b1 || req_ready !== 2'b10 || alu_mode !== 1'b0) begin
            bad++; $display("FAIL ms_vec_issue: got v=%b r=%b m=%b want v=1 r=10 m=0", alu_in_valid, req_ready, alu_mode); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        req_valid = 2'b11; req_mode = 2'b00;
        for (int k = 0; k < MO; k++) begin
            #1;
            total++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL full_accept[%0d]: got %b want %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10); end
            tick();
        end
        #1;
        total++; if (req_ready !== 2'b00 || alu_in_valid !== 1'b0) begin
            bad++; $display("FAIL full_block: got r=%b v=%b want r=00 v=0", req_ready, alu_in_valid); end
        tick();
        alu_out_valid = 1'b1;
        #1;
        total++; if (req_ready !== 2'b00 || resp_valid !== 2'b01) begin
            bad++; $display("FAIL full_pop_same: got r=%b resp=%b want r=00 resp=01", req_ready, resp_valid); end
        tick();
        alu_out_valid = 1'b0;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL full_after_pop: got %b want 01", req_ready); end
        tick();
    endtask

    task automatic test_protocol_error();
        do_reset();
        alu_out_valid = 1'b1;
        #1;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL perr_resp: got %b want 00", resp_valid); end
        tick();
        alu_out_valid = 1'b0;
        #1;
        total++; if (protocol_error !== 1'b1) begin bad++; $display("FAIL perr_set: got %b want 1", protocol_error); end
        tick(); tick();
        #1;
        total++; if (protocol_error !== 1'b1) begin bad++; $display("FAIL perr_sticky: got %b want 1", protocol_error); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (protocol_error !== 1'b0) begin bad++; $display("FAIL perr_clear: got %b want 0", protocol_error); end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 2'b11; req_mode = 2'b00;
        tick(); tick(); tick();
        req_valid = 2'b10;
        rst = 1'b1;
        #1;
        total++; if (alu_in_valid !== 1'b0 || req_ready !== 2'b00) begin
            bad++; $display("FAIL mid_rst_out: got v=%b r=%b want v=0 r=00", alu_in_valid, req_ready); end
        tick();
        rst = 1'b0; req_valid = 2'b11; alu_out_valid = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01 || resp_valid !== 2'b00) begin
            bad++; $display("FAIL mid_resume: got r=%b resp=%b want r=01 resp=00", req_ready, resp_valid); end
        tick();
        alu_out_valid = 1'b0; req_valid = 2'b00;
        #1;
        total++; if (protocol_error !== 1'b1) begin bad++; $display("FAIL mid_late_result: got %b want 1", protocol_error); end
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0] prev_ready;
        logic [NR-1:0] e_ready;
        int            c;
        bit            ei;
        do_reset();
        use_pipe   = 1'b1; lat = 6;
        prev_ready = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!(req_valid[i] && !prev_ready[i])) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_mode[i]  = ($urandom_range(0, 7) == 0);
                    req_a[i*VW +: VW]      = rnd_bits()[VW-1:0];
                    req_b[i*VW +: VW]      = rnd_bits()[VW-1:0];
                    req_c[i*W +: W]        = W'($urandom);
                    req_enable[i*NI +: NI] = NI'($urandom);
                end
            end
            alu_in_ready = ($urandom_range(0, 4) != 0);
            #1;
            c  = m_cand();
            ei = m_issue();
            e_ready = '0;
            if (ei && alu_in_ready) e_ready[c] = 1'b1;
            total++; if (alu_in_valid !== ei) begin
                bad++; $display("FAIL rnd_in_valid[%0d]: got %b want %b", cyc, alu_in_valid, ei); end
            total++; if (req_ready !== e_ready) begin
                bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, req_ready, e_ready); end
            total++; if (resp_valid !== m_resp()) begin
                bad++; $display("FAIL rnd_resp[%0d]: got %b want %b", cyc, resp_valid, m_resp()); end
            total++; if (protocol_error !== m_err) begin
                bad++; $display("FAIL rnd_perr[%0d]: got %b want %b", cyc, protocol_error, m_err); end
            if (ei) begin
                total++;
                if (alu_mode !== ((m_q.size() == 0) ? req_mode[c] : m_mode) ||
                    alu_a !== req_a[c*VW +: VW] || alu_b !== req_b[c*VW +: VW] ||
                    alu_c !== req_c[c*W +: W] || alu_enable !== req_enable[c*NI +: NI]) begin
                    bad++; $display("FAIL rnd_operands[%0d]: got m=%b a=%h c=%h want slice %0d", cyc, alu_mode, alu_a, alu_c, c);
                end
            end
            prev_ready = req_ready;
            tick();
        end
        use_pipe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_mode = '0; req_a = '0; req_b = '0;
        req_c = '0; req_enable = '0; alu_in_ready = 1'b0; alu_out_valid = 1'b0;
        alu_dot_out = '0; alu_vec_out = '0;
        #1;
        test_reset();
        test_round_robin();
        test_solo();
        test_mode_switch();
        test_full();
        test_protocol_error();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
